// File: rtl/search_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : search_req_queue
// Description : Lookup front-end for the search table. Incoming 16-bit keys
//               are buffered in a DEPTH-entry FIFO and issued one at a time
//               on the table's req/search port. The FSM waits for the table's
//               done pulse, or abandons the lookup after TIMEOUT cycles, and
//               returns key + found/result on a valid/ready response port.
// Ports       : clk, reset (async, active-low)
//               in_valid/in_key/in_ready         - key input (valid/ready)
//               tbl_req/tbl_search/tbl_rdy       - table request handshake
//               tbl_done/tbl_found/tbl_result    - table completion
//               out_valid/out_ready/out_key/out_found/out_result/out_timeout
//                                                - response (valid/ready)
//               count    - FIFO occupancy
//               timeouts - saturating count of abandoned lookups
// Revision    : 1.0 - initial release
// ============================================================================
module search_req_queue #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [15:0]              in_key,
    output logic                     in_ready,
    output logic                     tbl_req,
    output logic [15:0]              tbl_search,
    input  logic                     tbl_rdy,
    input  logic                     tbl_done,
    input  logic                     tbl_found,
    input  logic [15:0]              tbl_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_key,
    output logic                     out_found,
    output logic [15:0]              out_result,
    output logic                     out_timeout,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               timeouts
);

    localparam int               AW         = $clog2(DEPTH);
    localparam int               CW         = AW + 1;
    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
    // The timer starts at 0 on WAIT entry, so the TIMEOUT-th WAIT cycle is
    // the one where it holds TIMEOUT-1.
    localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      timer;

    logic            push;
    logic            done_hit;
    logic            expire;
    logic            pop;
    logic [15:0]     head_key;

    assign in_ready   = (count < FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign head_key   = mem[rd_ptr];

    // done takes priority over a simultaneous timer expiry
    assign done_hit   = (state == WAIT) && tbl_done;
    assign expire     = (state == WAIT) && !tbl_done && (timer == TIMER_LAST);
    assign pop        = done_hit || expire;

    // Request is a pure decode of the state so that a reset drops it at once.
    assign tbl_req    = (state == ISSUE);
    assign tbl_search = (state == ISSUE) ? head_key : 16'h0000;

    // Key storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_key;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            timer       <= 8'd0;
            timeouts    <= 8'd0;
            out_valid   <= 1'b0;
            out_key     <= 16'h0000;
            out_found   <= 1'b0;
            out_result  <= 16'h0000;
            out_timeout <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop in the same cycle cancel out.
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tbl_rdy) begin
                        state <= WAIT;
                        timer <= 8'd0;
                    end
                end
                WAIT: begin
                    if (done_hit) begin
                        out_valid   <= 1'b1;
                        out_key     <= head_key;
                        out_found   <= tbl_found;
                        out_result  <= tbl_result;
                        out_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (expire) begin
                        out_valid   <= 1'b1;
                        out_key     <= head_key;
                        out_found   <= 1'b0;
                        out_result  <= 16'h0000;
                        out_timeout <= 1'b1;
                        if (timeouts != 8'hFF) begin
                            timeouts <= timeouts + 8'd1;
                        end
                        state       <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= (count != '0) ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/search_req_queue.md
# search_req_queue

Front-end lookup stage that sits directly upstream of the search table and drives its `req`/`search` lookup port. It buffers incoming 16-bit search keys in a small FIFO, issues them one at a time to the table, and waits for `done`. It returns each key with its `found`/`result` on a valid/ready output, and flags lookups that exceed a timeout.

## Interface
- `DEPTH`, 8: key FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255: max cycles in WAIT before a lookup is abandoned; 1..255.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream key valid.
- `in_key`  in  16  key to look up.
- `in_ready`  out  1  FIFO can accept; equals (count < DEPTH).
- `tbl_req`  out  1  lookup request to table.
- `tbl_search`  out  16  key presented to table.
- `tbl_rdy`  in  1  table accepts a request this cycle.
- `tbl_done`  in  1  one-cycle completion pulse from table.
- `tbl_found`  in  1  hit flag, valid with `tbl_done`.
- `tbl_result`  in  16  table result, valid with `tbl_done`.
- `out_valid`  out  1  response valid.
- `out_ready`  in  1  downstream accepts response.
- `out_key`  out  16  key of this response.
- `out_found`  out  1  table hit.
- `out_result`  out  16  table result; 0 on miss-by-timeout.
- `out_timeout`  out  1  lookup abandoned.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `timeouts`  out  8  saturating count of abandoned lookups.

## Operation
- FIFO: push on `in_valid && in_ready`; pop at WAIT exit; read/write pointers wrap modulo DEPTH. Simultaneous push and pop leaves `count` unchanged. `in_valid` while full is ignored; the key is not stored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if count>0 → ISSUE; else stay.
- ISSUE: `tbl_req`=1 and `tbl_search`=FIFO head, both combinational from state. When `tbl_rdy`=1 → WAIT and clear timer; else hold with req asserted and key stable.
- WAIT: `tbl_req`=0 and timer increments each cycle.
  - On `tbl_done` → capture `tbl_found`/`tbl_result`, head key, `out_timeout`=0, pop → RESP.
  - Else, when timer reaches TIMEOUT → capture found=0, result=0, `out_timeout`=1, pop, increment `timeouts` (saturating at 255) → RESP.
  - `tbl_done` in the same cycle as timer expiry: done wins; this is not a timeout.
- RESP: `out_*` are held stable while `out_valid`=1. On `out_ready`: → ISSUE if count>0, else IDLE.
- `tbl_done` outside WAIT is ignored.
- A late done arriving during a later WAIT is attributed to that later key. This is a known limitation; the table's latency must stay below TIMEOUT.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, pointers=0, count=0, timer=0, timeouts=0. Outputs: `tbl_req`=0, `tbl_search`=0, `out_valid`=0, `out_key`=0, `out_found`=0, `out_result`=0, `out_timeout`=0, `in_ready`=1.
- Reset mid-lookup: any outstanding request is abandoned and `tbl_req` drops immediately. No response is produced for abandoned keys.
- Minimum latency with an empty FIFO:
  - Key pushed at edge E0.
  - ISSUE after E1; `tbl_req` is high in the cycle E1–E2.
  - With `tbl_rdy`=1 at E2 → WAIT.
  - Table `done` sampled at edge En → `out_valid`=1 after En.
- Table request handshake completes in the cycle where `tbl_req && tbl_rdy`. Exactly one request is issued per key.
- Back-to-back throughput with `out_ready` held high: one key per (table latency + 3) cycles.
- `in_ready` is registered from count, so it reflects occupancy after the previous edge.

## Test plan
- Single key: push 0x0028; table gives `rdy`=1, then `done` 2 cycles later with found=1, result=0x0044 → one response: key=0x0028, found=1, result=0x0044, timeout=0; `tbl_req` high exactly 1 cycle.
- Fill and wrap: DEPTH=8; push 0x0001–0x0008 with the table stalled (`tbl_rdy`=0) → `in_ready`=0, count=8, push of 0x0009 dropped. Release the table and push 10 more keys during drain → responses strictly in push order, pointers wrap, count returns to 0.
- Backpressure: hold `out_ready`=0 for 20 cycles in RESP → `out_*` stable, `tbl_req` stays 0, no pop.
- Timeout: TIMEOUT=16; table never sends done for key 0x0084 → response after 16 WAIT cycles with found=0, result=0, timeout=1, timeouts=1. A `done` arriving in exactly the expiry cycle → timeout=0, timeouts unchanged.
- Spurious done: pulse `tbl_done` in IDLE and ISSUE → no response, state unchanged.
- Reset mid-WAIT with 3 keys queued: assert `reset` → `tbl_req`=0, count=0, `out_valid`=0 immediately. After release, a fresh key 0x0024 completes normally.
